// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared types and helpers for the interrupt controller
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Source id width; a single source still needs a one-bit id.
    function automatic int idWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - combinational lowest-index-first priority encoder
module priority_encoder #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req_i,
    output logic          valid_o,
    output logic [IW-1:0] index_o
);

    // Scan from the top so the last hit, the lowest index, wins.
    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                index_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latched, masked, fixed-priority vectored interrupt responder
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter int              NUM_SRC       = 8,
    parameter logic [XLEN-1:0] VECTOR_BASE   = XLEN'(32'h0000_0100),
    parameter int              VECTOR_STRIDE = 4,
    localparam int             IW            = idWidth(NUM_SRC)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] irqSrc,
    input  logic               maskWe,
    input  logic [NUM_SRC-1:0] maskData,
    input  logic               eoi,
    output logic               interruptRequest,
    output logic [XLEN-1:0]    handlerAddr,
    input  logic               interruptTaken,
    output logic [IW-1:0]      activeId,
    output logic               busy,
    output logic [NUM_SRC-1:0] pendingOut
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] irq_hist_q, pending_q, pending_d, mask_q, mask_d;
    logic [NUM_SRC-1:0] src_edge, eligible, clr_onehot;
    logic               req_q, req_d, busy_q, busy_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [IW-1:0]      id_q, id_d;
    logic               win_valid;
    logic [IW-1:0]      win_idx;

    assign src_edge = irqSrc & ~irq_hist_q;
    assign eligible = pending_q & mask_q;

    // A fresh edge on the bit being taken re-sets it, so that event survives.
    assign pending_d = (pending_q & ~clr_onehot) | src_edge;
    assign mask_d    = maskWe ? maskData : mask_q;

    priority_encoder #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_prio (
        .req_i   (eligible),
        .valid_o (win_valid),
        .index_o (win_idx)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        id_d       = id_q;
        busy_d     = busy_q;
        clr_onehot = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    id_d    = win_idx;
                    addr_d  = VECTOR_BASE + XLEN'(win_idx) * XLEN'(VECTOR_STRIDE);
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Acceptance beats a same-cycle mask withdrawal.
                if (interruptTaken) begin
                    clr_onehot[id_q] = 1'b1;
                    req_d            = 1'b0;
                    busy_d           = 1'b1;
                    state_d          = ST_SERVICE;
                end else if (!mask_q[id_q]) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            irq_hist_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= VECTOR_BASE;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            irq_hist_q <= irqSrc;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
        end
    end

    assign interruptRequest = req_q;
    assign handlerAddr      = addr_q;
    assign activeId         = id_q;
    assign busy             = busy_q;
    assign pendingOut       = pending_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Responder side of the CPU core's interrupt handshake (interruptRequest / handlerAddr / interruptTaken). It collects up to NUM_SRC peripheral interrupt lines, edge-detects and latches them as pending, applies a software-written enable mask, and arbitrates by fixed priority. It presents one request with a stable vectored handler address to the core, then waits for an end-of-interrupt pulse before offering the next one. It sits beside the CPU top in the SoC, between peripherals and the core.

Parameters:
XLEN, 32, width of handlerAddr and vector arithmetic
NUM_SRC, 8, number of interrupt sources (1..32)
VECTOR_BASE, 32'h0000_0100, handler address of source 0
VECTOR_STRIDE, 4, byte distance between consecutive source handlers

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous reset, active low
irqSrc  in  NUM_SRC  peripheral interrupt lines, synchronous to clock, rising edge = event
maskWe  in  1  write strobe for enable mask
maskData  in  NUM_SRC  new enable mask (1 = enabled)
eoi  in  1  end-of-interrupt pulse from core (handler return)
interruptRequest  out  1  request to core
handlerAddr  out  XLEN  vector for current request
interruptTaken  in  1  core accepted the request
activeId  out  $clog2(NUM_SRC) (min 1)  id being requested or serviced
busy  out  1  high in SERVICE state
pendingOut  out  NUM_SRC  current pending register

Behaviour:
- Interface: single clock `clock`; reset `resetn` is asynchronous, active low.
- Reset values: interruptRequest=0, handlerAddr=VECTOR_BASE, activeId=0, busy=0, pending=0, mask=0 (all disabled), irqSrc edge-history register=0, state=IDLE.
- Edge detect: pending[i] set at a clock edge when irqSrc[i]=1 and the previous sample was 0. A level held high produces one event only. Masked sources still latch pending.
- mask is updated from maskData at the clock edge where maskWe=1.
- Eligible set = pending & mask. Priority: lowest index wins.
- FSM: IDLE, REQ, SERVICE. All outputs are registered.
- IDLE: if eligible is nonzero, latch winner into activeId, set handlerAddr = VECTOR_BASE + activeId*VECTOR_STRIDE (XLEN-bit, wraps mod 2^XLEN), assert interruptRequest, and go to REQ.
- Latency: irqSrc first sampled high at edge k gives pending at edge k; interruptRequest goes high after edge k+1.
- REQ: interruptRequest, handlerAddr and activeId are held stable. A higher-priority arrival does not preempt the held id.
- REQ, interruptTaken=1: clear pending[activeId], deassert interruptRequest, set busy=1, go to SERVICE.
- REQ, mask[activeId] cleared and interruptTaken=0: withdraw, meaning interruptRequest=0 and state goes to IDLE. pending is kept.
- REQ, mask clear and interruptTaken in the same cycle: taken wins.
- SERVICE: wait for eoi. On eoi, busy=0 and state goes to IDLE. New edges still latch pending. The next request can be raised at the earliest one cycle after IDLE is re-entered (no IDLE->REQ in the eoi cycle).
- interruptTaken outside REQ is ignored. eoi outside SERVICE is ignored.
- Set and clear of the same pending bit in one cycle (new edge while being taken): set wins, so the event is not lost.
- Reset asserted mid-operation: immediate return to all reset values, including clearing pending and mask.

Decomposition:
- Shared package: FSM state enum (IDLE/REQ/SERVICE) and the ID width function `idWidth(NUM_SRC)`.
- One natural sub-module: `priority_encoder`. It is combinational, lowest-index-first, and outputs `valid` and `index`.
- Edge detection, pending, mask and FSM stay in the top module.

Test Plan:
1. Reset, then irqSrc[3] pulses with mask=8'h08 -> interruptRequest high 2 edges after sampling, handlerAddr=0x10C, activeId=3. interruptTaken -> busy=1, pendingOut=0. eoi -> busy=0, IDLE.
2. irqSrc[5] and irqSrc[2] rise together, mask=8'hFF -> id 2 first (0x108). After eoi, id 5 (0x114) requested with no second edge needed.
3. In REQ for id 6, irqSrc[0] rises -> request stays id 6, 0x118. After eoi, id 0 (0x100) requested.
4. In REQ for id 4, write mask=8'h00 -> interruptRequest drops next cycle and pendingOut[4] stays 1. Rewrite mask=8'h10 -> re-request at 0x110.
5. irqSrc[1] rises in the same cycle interruptTaken accepts id 1 -> pendingOut[1]=1 after the edge, and id 1 is requested again after eoi. irqSrc[7] held high for 20 cycles -> exactly one service.
6. Assert resetn=0 during SERVICE -> busy=0, interruptRequest=0, pendingOut=0, mask cleared. Stray interruptTaken or eoi in IDLE -> no state change.
